// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg: shared constants for the HD44780-style bus receiver. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  localparam int LINES     = 2;
  localparam int COLS      = 16;
  localparam int BUF_DEPTH = LINES * COLS;
  localparam int IDX_W     = 5;
  localparam int ADDR_W    = 7;

  // Opcode class bits, highest set bit selects the instruction
  localparam int BIT_DDRAM = 7;
  localparam int BIT_CGRAM = 6;
  localparam int BIT_FSET  = 5;
  localparam int BIT_SHIFT = 4;
  localparam int BIT_DCTRL = 3;
  localparam int BIT_ENTRY = 2;
  localparam int BIT_HOME  = 1;
  localparam int BIT_CLEAR = 0;

  localparam int FSET_DL   = 4;
  localparam int FSET_N    = 3;
  localparam int SHIFT_SC  = 3;
  localparam int SHIFT_RL  = 2;
  localparam int DCTRL_D   = 2;
  localparam int ENTRY_ID  = 1;
  localparam int ENTRY_S   = 0;

  localparam logic [ADDR_W-1:0] LINE0_FIRST  = 7'h00;
  localparam logic [ADDR_W-1:0] LINE0_LAST   = 7'h0F;
  localparam logic [ADDR_W-1:0] LINE1_FIRST  = 7'h40;
  localparam logic [ADDR_W-1:0] LINE1_LAST   = 7'h4F;
  localparam logic [ADDR_W-1:0] WRAP_L0_END  = 7'h27;
  localparam logic [ADDR_W-1:0] WRAP_L1_END  = 7'h67;
  localparam logic [ADDR_W-1:0] ONE_LINE_END = 7'h4F;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  function automatic logic addr_visible(input logic [ADDR_W-1:0] a);
    return (a <= LINE0_LAST) || ((a >= LINE1_FIRST) && (a <= LINE1_LAST));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_addr_step.sv
// ----------------------------------------------------------------------------
// lcd_addr_step: next DDRAM address for a +/-1 cursor step with line wrap. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lcd_addr_step
  import lcd_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              dir_inc,
  input  logic              two_line,
  output logic [ADDR_W-1:0] next_addr
);

  always_comb begin
    next_addr = dir_inc ? (addr + 7'd1) : (addr - 7'd1);
    if (two_line) begin
      if (dir_inc && (addr == WRAP_L0_END))       next_addr = LINE1_FIRST;
      else if (dir_inc && (addr == WRAP_L1_END))  next_addr = LINE0_FIRST;
      else if (!dir_inc && (addr == LINE0_FIRST)) next_addr = WRAP_L1_END;
      else if (!dir_inc && (addr == LINE1_FIRST)) next_addr = WRAP_L0_END;
    end else begin
      if (dir_inc && (addr == ONE_LINE_END))      next_addr = LINE0_FIRST;
      else if (!dir_inc && (addr == LINE0_FIRST)) next_addr = ONE_LINE_END;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
// ----------------------------------------------------------------------------
// lcd_bus_receiver: HD44780 8-bit bus decoder with 2x16 shadow buffer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RS,
  input  logic              EN_OUT,
  input  logic [7:0]        data_LCD,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [7:0]        rd_char,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              display_on,
  output logic              two_line,
  output logic              busy,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic              char_valid,
  output logic              err_unsupported,
  output logic              err_overrun
);

  logic [SYNC_STAGES-1:0]      rs_sync_q, rs_sync_d;
  logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
  logic                        en_prev_q;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sweep_idx_q, sweep_idx_d;
  logic [ADDR_W-1:0]   cursor_addr_q, cursor_addr_d;
  logic                inc_q, inc_d;
  logic                display_on_q, display_on_d;
  logic                two_line_q, two_line_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [7:0]          cmd_code_q, cmd_code_d;
  logic                char_valid_q, char_valid_d;
  logic                err_unsup_q, err_unsup_d;
  logic                err_overrun_q, err_overrun_d;
  logic [7:0]          rd_char_q;
  logic [7:0]          mem_q [BUF_DEPTH];

  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [7:0]          wr_data;
  logic                strobe, rs_s, step_dir;
  logic [7:0]          data_s;
  logic [ADDR_W-1:0]   step_addr;

  // RS and data come from the same stage as EN so a strobe sees a stable bus
  assign strobe   = en_prev_q & ~en_sync_q[SYNC_STAGES-1];
  assign rs_s     = rs_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign step_dir = rs_s ? inc_q : data_s[SHIFT_RL];

  lcd_addr_step u_step (
    .addr      (cursor_addr_q),
    .dir_inc   (step_dir),
    .two_line  (two_line_q),
    .next_addr (step_addr)
  );

  always_comb begin
    rs_sync_d      = rs_sync_q;
    en_sync_d      = en_sync_q;
    data_sync_d    = data_sync_q;
    rs_sync_d[0]   = RS;
    en_sync_d[0]   = EN_OUT;
    data_sync_d[0] = data_LCD;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      rs_sync_d[i]   = rs_sync_q[i-1];
      en_sync_d[i]   = en_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_idx_d   = sweep_idx_q;
    cursor_addr_d = cursor_addr_q;
    inc_d         = inc_q;
    display_on_d  = display_on_q;
    two_line_d    = two_line_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    char_valid_d  = 1'b0;
    err_unsup_d   = err_unsup_q;
    err_overrun_d = err_overrun_q;
    wr_en         = 1'b0;
    wr_idx        = sweep_idx_q;
    wr_data       = BLANK_CHAR;

    if (state_q == ST_SWEEP) begin
      wr_en       = 1'b1;
      sweep_idx_d = sweep_idx_q + 5'd1;
      if (sweep_idx_q == IDX_W'(BUF_DEPTH - 1)) begin
        state_d       = ST_IDLE;
        cursor_addr_d = '0;
        inc_d         = 1'b1;
      end
      if (strobe) err_overrun_d = 1'b1;
    end else if (strobe) begin
      if (rs_s) begin
        char_valid_d = 1'b1;
        if (addr_visible(cursor_addr_q)) begin
          wr_en   = 1'b1;
          wr_idx  = {cursor_addr_q[6], cursor_addr_q[3:0]};
          wr_data = data_s;
        end
        cursor_addr_d = step_addr;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = data_s;
        if (data_s[BIT_DDRAM]) begin
          cursor_addr_d = data_s[ADDR_W-1:0];
        end else if (data_s[BIT_CGRAM]) begin
          err_unsup_d = 1'b1;
        end else if (data_s[BIT_FSET]) begin
          two_line_d = data_s[FSET_N];
          if (!data_s[FSET_DL]) err_unsup_d = 1'b1;
        end else if (data_s[BIT_SHIFT]) begin
          if (data_s[SHIFT_SC]) err_unsup_d = 1'b1;
          else                  cursor_addr_d = step_addr;
        end else if (data_s[BIT_DCTRL]) begin
          display_on_d = data_s[DCTRL_D];
        end else if (data_s[BIT_ENTRY]) begin
          inc_d = data_s[ENTRY_ID];
          if (data_s[ENTRY_S]) err_unsup_d = 1'b1;
        end else if (data_s[BIT_HOME]) begin
          cursor_addr_d = '0;
        end else if (data_s[BIT_CLEAR]) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rs_sync_q     <= '0;
      en_sync_q     <= '0;
      data_sync_q   <= '0;
      en_prev_q     <= 1'b0;
      state_q       <= ST_SWEEP;
      sweep_idx_q   <= '0;
      cursor_addr_q <= '0;
      inc_q         <= 1'b1;
      display_on_q  <= 1'b0;
      two_line_q    <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      char_valid_q  <= 1'b0;
      err_unsup_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      rd_char_q     <= BLANK_CHAR;
    end else begin
      rs_sync_q     <= rs_sync_d;
      en_sync_q     <= en_sync_d;
      data_sync_q   <= data_sync_d;
      en_prev_q     <= en_sync_q[SYNC_STAGES-1];
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      cursor_addr_q <= cursor_addr_d;
      inc_q         <= inc_d;
      display_on_q  <= display_on_d;
      two_line_q    <= two_line_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      char_valid_q  <= char_valid_d;
      err_unsup_q   <= err_unsup_d;
      err_overrun_q <= err_overrun_d;
      rd_char_q     <= mem_q[rd_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_char         = rd_char_q;
  assign cursor_addr     = cursor_addr_q;
  assign display_on      = display_on_q;
  assign two_line        = two_line_q;
  assign busy            = (state_q == ST_SWEEP);
  assign cmd_valid       = cmd_valid_q;
  assign cmd_code        = cmd_code_q;
  assign char_valid      = char_valid_q;
  assign err_unsupported = err_unsup_q;
  assign err_overrun     = err_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
// ----------------------------------------------------------------------------
// tb_lcd_bus_receiver: directed self-checking bench for lcd_bus_receiver. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lcd_bus_receiver;

  logic       clk;
  logic       rst_n;
  logic       rs;
  logic       en_out;
  logic [7:0] data_lcd;
  logic [4:0] rd_idx;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on, two_line, busy;
  logic       cmd_valid, char_valid;
  logic [7:0] cmd_code;
  logic       err_unsupported, err_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int char_cnt = 0;

  lcd_bus_receiver #(.SYNC_STAGES(2), .BLANK_CHAR(8'h20)) dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .RS              (rs),
    .EN_OUT          (en_out),
    .data_LCD        (data_lcd),
    .rd_idx          (rd_idx),
    .rd_char         (rd_char),
    .cursor_addr     (cursor_addr),
    .display_on      (display_on),
    .two_line        (two_line),
    .busy            (busy),
    .cmd_valid       (cmd_valid),
    .cmd_code        (cmd_code),
    .char_valid      (char_valid),
    .err_unsupported (err_unsupported),
    .err_overrun     (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (char_valid) char_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus strobe; measures cycles from the EN fall to the valid pulse (0 = none)
  task automatic send(input logic rs_v, input logic [7:0] d, input int exp_lat, input int wait_n);
    int lat;
    lat = 0;
    @(negedge clk);
    rs = rs_v; data_lcd = d; en_out = 1'b1;
    repeat (2) @(negedge clk);
    en_out = 1'b0;
    for (int i = 1; i <= wait_n; i++) begin
      @(negedge clk);
      if ((cmd_valid || char_valid) && lat == 0) lat = i;
    end
    check($sformatf("latency_%0d_%02h", rs_v, d), lat, exp_lat);
  endtask

  task automatic read_chk(input int idx, input logic [7:0] exp);
    rd_idx = idx[4:0];
    @(negedge clk);
    check($sformatf("buf[%0d]", idx), {24'd0, rd_char}, {24'd0, exp});
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int c0;
    rst_n = 1'b0; rs = 1'b0; en_out = 1'b0; data_lcd = 8'h00; rd_idx = 5'd0;
    repeat (3) @(negedge clk);

    check("rst_cursor", cursor_addr, 7'h00);
    check("rst_display_on", display_on, 0);
    check("rst_two_line", two_line, 1);
    check("rst_busy", busy, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_err_unsup", err_unsupported, 0);
    check("rst_err_overrun", err_overrun, 0);
    check("rst_rd_char", rd_char, 8'h20);

    rst_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, 32);
    for (int i = 0; i < 32; i++) read_chk(i, 8'h20);

    c0 = char_cnt;
    send(1'b0, 8'h38, 3, 5);
    send(1'b0, 8'h0C, 3, 5);
    send(1'b0, 8'h06, 3, 5);
    check("cmd_code_06", cmd_code, 8'h06);
    send(1'b1, 8'h48, 3, 5);
    send(1'b1, 8'h49, 3, 5);
    check("two_line_38", two_line, 1);
    check("display_on_0c", display_on, 1);
    check("cursor_hi", cursor_addr, 7'h02);
    check("char_pulses", char_cnt - c0, 2);
    read_chk(0, 8'h48);
    read_chk(1, 8'h49);

    send(1'b0, 8'hC0, 3, 5);
    for (int i = 0; i < 17; i++) send(1'b1, 8'h41, 3, 5);
    check("cursor_line1_end", cursor_addr, 7'h51);
    for (int i = 16; i < 32; i++) read_chk(i, 8'h41);
    read_chk(0, 8'h48);
    read_chk(1, 8'h49);
    read_chk(2, 8'h20);
    read_chk(15, 8'h20);

    send(1'b0, 8'hA7, 3, 5);
    check("cursor_a7", cursor_addr, 7'h27);
    send(1'b1, 8'h5A, 3, 5);
    check("cursor_wrap_27", cursor_addr, 7'h40);
    read_chk(7, 8'h20);
    send(1'b0, 8'h04, 3, 5);
    send(1'b1, 8'h33, 3, 5);
    check("cursor_wrap_back_40", cursor_addr, 7'h27);
    read_chk(16, 8'h33);
    check("err_unsup_clean", err_unsupported, 0);

    send(1'b0, 8'h01, 3, 5);
    check("busy_after_clear", busy, 1);
    send(1'b1, 8'h77, 0, 6);
    check("err_overrun", err_overrun, 1);
    wait_idle();
    check("cursor_after_clear", cursor_addr, 7'h00);
    for (int i = 0; i < 32; i++) read_chk(i, 8'h20);

    send(1'b0, 8'h40, 3, 5);
    check("err_cgram", err_unsupported, 1);
    check("cursor_cgram", cursor_addr, 7'h00);
    pulse_reset();
    check("err_unsup_reset", err_unsupported, 0);
    check("err_overrun_reset", err_overrun, 0);
    wait_idle();

    send(1'b0, 8'h14, 3, 5);
    check("shift_right", cursor_addr, 7'h01);
    check("shift_right_no_err", err_unsupported, 0);
    send(1'b0, 8'h18, 3, 5);
    check("err_display_shift", err_unsupported, 1);
    check("cursor_display_shift", cursor_addr, 7'h01);
    pulse_reset();
    wait_idle();

    send(1'b0, 8'h30, 3, 5);
    send(1'b0, 8'h80, 3, 5);
    send(1'b0, 8'h10, 3, 5);
    check("one_line_wrap_down", cursor_addr, 7'h4F);
    check("one_line_mode", two_line, 0);
    check("one_line_no_err", err_unsupported, 0);
    send(1'b0, 8'h28, 3, 5);
    check("err_4bit", err_unsupported, 1);
    check("two_line_28", two_line, 1);
    check("cursor_28", cursor_addr, 7'h4F);
    pulse_reset();
    check("err_unsup_reset2", err_unsupported, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Synthesizable receiver for the HD44780-style 8-bit parallel LCD bus driven by sp_optimizer (RS, EN_OUT, data_LCD).
- Decodes instructions and character writes and keeps a 2x16 shadow display buffer with a registered read port.
- Provides error and status flags.
- Used on-chip as a loopback monitor and in benches as a self-checking display model.

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied to RS, EN_OUT and data_LCD.
- BLANK_CHAR, 8'h20, fill value written on clear and after reset.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- RS  in  1  register select: 0 = instruction, 1 = data.
- EN_OUT  in  1  LCD enable strobe; the bus is latched on its falling edge.
- data_LCD  in  8  bus data.
- rd_idx  in  5  buffer read index, {line, col[3:0]}.
- rd_char  out  8  buffer content at rd_idx, registered.
- cursor_addr  out  7  current DDRAM address counter.
- display_on  out  1  D bit from display-control instruction.
- two_line  out  1  N bit from function set.
- busy  out  1  clear sweep in progress.
- cmd_valid  out  1  one-cycle pulse per accepted instruction.
- cmd_code  out  8  last instruction byte, valid with cmd_valid.
- char_valid  out  1  one-cycle pulse per accepted data write.
- err_unsupported  out  1  sticky: CGRAM address set, display shift (S=1 or S/C=1), or 4-bit function set.
- err_overrun  out  1  sticky: bus strobe received while busy.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - Outputs: cursor_addr=0, display_on=0, two_line=1, busy=1, cmd_valid=0, char_valid=0, err_* = 0, rd_char=BLANK_CHAR.
  - Increment mode (I/D) = 1.
  - A reset-initiated clear sweep then writes BLANK_CHAR into all 32 entries, one per cycle (index 0..31). busy=0 after 32 cycles.
  - Reset asserted mid-sweep restarts the sweep from index 0.
- Input path: RS, EN_OUT and data_LCD each pass through SYNC_STAGES flops, plus one edge flop on EN.
  - Strobe = synced EN 1->0.
  - RS and data are taken from the same sync stage as EN, so they stay aligned.
  - Latency from pin EN fall to the cmd_valid/char_valid pulse and the buffer update: SYNC_STAGES+1 cycles.
- Strobe while busy=1: ignored, err_overrun set.
- Instruction decode (RS=0), priority from MSB:
  - 1xxxxxxx DDRAM set: cursor_addr = data[6:0].
  - 01xxxxxx CGRAM set: err_unsupported, no other effect.
  - 001xxxxx function set: two_line=data[3]; if data[4]=0, err_unsupported.
  - 0001xxxx cursor/display shift: if data[3]=1, err_unsupported; else move the cursor by ±1 (data[2]=1 right) using the wrap rule below.
  - 00001xxx display control: display_on=data[2].
  - 000001xx entry mode: I/D=data[1]; if data[0]=1, err_unsupported.
  - 0000001x return home: cursor_addr=0.
  - 00000001 clear: start a 32-cycle sweep (busy=1), then cursor_addr=0 and I/D=1.
  - 00000000: no-op, still pulses cmd_valid.
- Data write (RS=1):
  - If cursor_addr is visible (0x00-0x0F → line 0, 0x40-0x4F → line 1), write buffer[{addr[6],addr[3:0]}] = data.
  - Writes to non-visible addresses are dropped silently.
  - In all cases char_valid pulses and the cursor steps per I/D.
- Cursor step and wrap:
  - two_line=1: +1 from 0x27 goes to 0x40, +1 from 0x67 goes to 0x00; -1 from 0x00 goes to 0x67, -1 from 0x40 goes to 0x27.
  - two_line=0: range 0x00-0x4F with wrap at both ends.
  - A DDRAM set to an out-of-range address is accepted unchanged. The next step from it is plain ±1, mod 128.
- Read port: rd_char = buffer[rd_idx] one cycle after rd_idx is presented. A write and a read to the same index in the same cycle return the old value.
- Single clock domain; no combinational path from input to output.

Decomposition:
- Package lcd_pkg holds:
  - Instruction opcode masks and bit positions.
  - Visible-window bounds (0x00, 0x0F, 0x40, 0x4F) and wrap constants (0x27, 0x67).
  - Buffer geometry (LINES=2, COLS=16).
- One sub-module, lcd_addr_step: combinational next-address function (addr, dir, two_line → next addr). It is shared by data writes and cursor-shift instructions.

Test Plan:
- Reset, then sample rd_char for all 32 indices → all 0x20; busy=1 for 32 cycles after RST_N rises, then 0.
- Instr 0x38, 0x0C, 0x06; data 'H' (0x48), 'I' (0x49) → two_line=1, display_on=1, buffer[0]=0x48, buffer[1]=0x49, cursor_addr=0x02, two char_valid pulses, each SYNC_STAGES+1 cycles after its EN fall.
- Instr 0xC0, then 17 data writes of 0x41 → buffer[16..31]=0x41, cursor_addr=0x51, buffer[0..15] unchanged.
- cursor_addr set to 0x27 (instr 0xA7), data 0x5A → no visible write, cursor_addr=0x40; then instr 0x04 and a data write → cursor steps back to 0x3F? No: -1 from 0x40 gives cursor_addr=0x27.
- Instr 0x01, then an EN strobe 5 cycles later → strobe ignored, err_overrun=1, buffer all 0x20 after 32 cycles, cursor_addr=0.
- Instr 0x40, 0x18, 0x28 → err_unsupported=1, cursor_addr unchanged, two_line=1; RST_N low for one cycle clears err_unsupported.
